// File: rtl/regfile_write_decoder.sv
// Write side of the integer register file: decodes the destination register number into
// one-hot write enables and holds every register, presented as one flat bus for the read muxes.
module regfile_write_decoder #(
  parameter int WIDTH    = 64,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 31
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     RegWrite,
  input  logic [$clog2(NREG)-1:0]  WriteRegister,
  input  logic [WIDTH-1:0]         WriteData,
  output logic [NREG*WIDTH-1:0]    regs_out,
  output logic [NREG-1:0]          wr_onehot
);

  localparam int AW    = $clog2(NREG);
  localparam int LOW_W = AW - 2;
  localparam int LOW_N = 1 << LOW_W;

  logic [3:0]       pre_hi;
  logic [LOW_N-1:0] dec_lo;

  // RegWrite is folded into the top-bit predecode, so an unknown register number
  // while RegWrite is low can never raise an enable.
  for (genvar h = 0; h < 4; h++) begin : g_pre_hi
    assign pre_hi[h] = RegWrite & (WriteRegister[AW-1 -: 2] == 2'(h));
  end

  for (genvar l = 0; l < LOW_N; l++) begin : g_dec_lo
    assign dec_lo[l] = (WriteRegister[LOW_W-1:0] == LOW_W'(l));
  end

  for (genvar h = 0; h < 4; h++) begin : g_row
    for (genvar l = 0; l < LOW_N; l++) begin : g_col
      localparam int K = h * LOW_N + l;
      if (K == ZERO_REG) begin : g_zero
        assign wr_onehot[K]                = 1'b0;
        assign regs_out[K*WIDTH +: WIDTH]  = '0;
      end else begin : g_reg
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] d;

        assign wr_onehot[K] = pre_hi[h] & dec_lo[l];
        assign d            = wr_onehot[K] ? WriteData : q;

        always_ff @(posedge clk) begin
          if (reset) q <= '0;
          else       q <= d;
        end

        assign regs_out[K*WIDTH +: WIDTH] = q;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_decoder.sv
// Scoreboard bench for regfile_write_decoder: a driver pushes the expected post-edge register
// image and decoder enables per cycle, a monitor pops and compares just after each rising edge.
module tb_regfile_write_decoder;

  localparam int WIDTH    = 64;
  localparam int NREG     = 32;
  localparam int ZERO_REG = 31;

  typedef struct {
    logic [NREG*WIDTH-1:0] regs;
    logic [NREG-1:0]       onehot;
    string                 tag;
  } exp_t;

  logic                  clk;
  logic                  reset;
  logic                  RegWrite;
  logic [4:0]            WriteRegister;
  logic [WIDTH-1:0]      WriteData;
  logic [NREG*WIDTH-1:0] regs_out;
  logic [NREG-1:0]       wr_onehot;

  exp_t             sb[$];
  logic [WIDTH-1:0] model[NREG];
  int               vectors    = 0;
  int               miscompares = 0;
  int               fail_prints = 0;

  regfile_write_decoder #(.WIDTH(WIDTH), .NREG(NREG), .ZERO_REG(ZERO_REG)) dut (
    .clk          (clk),
    .reset        (reset),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .regs_out     (regs_out),
    .wr_onehot    (wr_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a plain array of registers; reset clears all, a write stores unless it
  // targets the zero register. Enables are simply "1 << number" when a real write is requested.
  task automatic applyStimulus(input logic rst, input logic rw, input logic [4:0] addr,
                               input logic [WIDTH-1:0] data, input string tag);
    exp_t e;
    @(negedge clk);
    reset         = rst;
    RegWrite      = rw;
    WriteRegister = addr;
    WriteData     = data;
    e.onehot = '0;
    if (rw && (addr != ZERO_REG)) e.onehot = NREG'(1) << addr;
    if (rst) begin
      for (int k = 0; k < NREG; k++) model[k] = '0;
    end else if (rw && (addr != ZERO_REG)) begin
      model[addr] = data;
    end
    for (int k = 0; k < NREG; k++) e.regs[k*WIDTH +: WIDTH] = model[k];
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    bit bad = 0;
    vectors++;
    for (int k = 0; k < NREG; k++) begin
      if (regs_out[k*WIDTH +: WIDTH] !== e.regs[k*WIDTH +: WIDTH]) begin
        bad = 1;
        if (fail_prints < 40) begin
          fail_prints++;
          $display("[TB] FAIL %s reg%0d: got %h expected %h", e.tag, k,
                   regs_out[k*WIDTH +: WIDTH], e.regs[k*WIDTH +: WIDTH]);
        end
      end
    end
    if (wr_onehot !== e.onehot) begin
      bad = 1;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("[TB] FAIL %s wr_onehot: got %h expected %h", e.tag, wr_onehot, e.onehot);
      end
    end
    if (bad) miscompares++;
  endtask

  // Monitor: every cycle the DUT presents a fresh register image just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  initial begin
    logic [7:0]       kk;
    logic [4:0]       a;
    logic [WIDTH-1:0] d;
    int               pick;

    reset         = 1'b1;
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    for (int k = 0; k < NREG; k++) model[k] = '0;

    applyStimulus(1'b1, 1'b0, 5'd0, '0, "reset");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 5'(i * 7), '1, "idle_after_reset");

    for (int k = 0; k < ZERO_REG; k++) begin
      kk = 8'(k);
      applyStimulus(1'b0, 1'b1, 5'(k), {32'hA5A5_0000, 24'h0, kk}, "fill");
    end
    applyStimulus(1'b0, 1'b0, 5'd0, '0, "readback");

    applyStimulus(1'b0, 1'b1, 5'd31, '1, "zero_reg_write");

    applyStimulus(1'b0, 1'b0, 5'd5, 64'hDEAD_BEEF_DEAD_BEEF, "rw_low");
    applyStimulus(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF_DEAD_BEEF, "rw_high");

    applyStimulus(1'b0, 1'b1, 5'd7, 64'h1, "b2b_first");
    applyStimulus(1'b0, 1'b1, 5'd7, 64'h2, "b2b_second");

    applyStimulus(1'b0, 1'b0, 5'bxxxxx, 64'h0123_4567_89AB_CDEF, "x_addr_idle");

    applyStimulus(1'b0, 1'b1, 5'd3, 64'h55, "x3_set");
    applyStimulus(1'b1, 1'b1, 5'd3, 64'hFF, "reset_beats_write");
    applyStimulus(1'b0, 1'b0, 5'd3, 64'hFF, "after_reset");

    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 9);
      if (pick == 0)      a = 5'd31;
      else if (pick == 1) a = 5'd7;
      else                a = 5'($urandom_range(0, NREG - 1));
      d = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) d = '1;
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), a, d, "random");
    end

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      $display("[TB] FAIL drain_timeout: %0d entries left, expected 0", sb.size());
      miscompares++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
